// File: rtl/i2c_bus_frontend_pkg.sv
// Shared types and constants for the I2C bus front end.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } i2c_state_e;

  localparam int   BYTE_W        = 8;
  localparam int   BITS_PER_BYTE = 8;
  localparam logic IDLE_LINE     = 1'b1;

endpackage

// File: rtl/i2c_bus_frontend_if.sv
// Bus-side and event-side signals of the I2C front end; slave modport is the front end itself.
interface i2c_bus_frontend_if;
  import i2c_pkg::*;

  logic              scl_in;
  logic              sda_in;
  logic              scl_f;
  logic              sda_f;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;
  logic              bus_busy;
  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              frame_first;
  logic              ack_valid;
  logic              ack_bit;
  logic              timeout;

  modport slave (
    input  scl_in, sda_in,
    output scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy,
           byte_valid, byte_data, frame_first, ack_valid, ack_bit, timeout
  );

  modport master (
    output scl_in, sda_in,
    input  scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy,
           byte_valid, byte_data, frame_first, ack_valid, ack_bit, timeout
  );

endinterface

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output only follows
// the synchronised line after FILTER_LEN consecutive disagreeing cycles.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic filt_o
);

  logic [1:0] sync_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{IDLE_LINE}};
      filt_q <= IDLE_LINE;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/i2c_bus_frontend.sv
// I2C slave front end: filtered lines, START/STOP detection, byte and ACK assembly.
// Optional bus timeout is compiled in with I2C_TIMEOUT_EN.
module i2c_bus_frontend
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  i2c_bus_frontend_if.slave  bus
);

  localparam int BIT_CNT_W = $clog2(BITS_PER_BYTE) + 1;

  logic scl_f, sda_f;
  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_ev, stop_ev, tmo;

  i2c_state_e          state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [BYTE_W-1:0]    byte_data_q, byte_data_d;
  logic first_q, first_d;
  logic busy_q, busy_d;
  logic byte_valid_q, byte_valid_d;
  logic frame_first_q, frame_first_d;
  logic ack_valid_q, ack_valid_d;
  logic ack_bit_q, ack_bit_d;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .raw_i(bus.scl_in), .filt_o(scl_f)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .raw_i(bus.sda_in), .filt_o(sda_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= IDLE_LINE;
      sda_prev_q <= IDLE_LINE;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  // Requiring SCL high on both cycles keeps a simultaneous SCL/SDA change from reading as START/STOP.
  assign scl_rise = scl_f & ~scl_prev_q;
  assign scl_fall = ~scl_f & scl_prev_q;
  assign start_ev = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_ev  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

`ifdef I2C_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    tmo      = 1'b0;
    if (busy_q && !scl_f) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    first_d       = first_q;
    busy_d        = busy_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    frame_first_d = 1'b0;
    ack_valid_d   = 1'b0;
    ack_bit_d     = ack_bit_q;
    if (start_ev) begin
      state_d   = DATA;
      bit_cnt_d = '0;
      first_d   = 1'b1;
      busy_d    = 1'b1;
    end else if (stop_ev || tmo) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        DATA: begin
          shift_d = {shift_q[BYTE_W-2:0], sda_f};
          if (bit_cnt_q == BIT_CNT_W'(BITS_PER_BYTE - 1)) begin
            byte_data_d   = shift_d;
            byte_valid_d  = 1'b1;
            frame_first_d = first_q;
            first_d       = 1'b0;
            bit_cnt_d     = '0;
            state_d       = ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ACK: begin
          ack_valid_d = 1'b1;
          ack_bit_d   = sda_f;
          bit_cnt_d   = '0;
          state_d     = DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      first_q       <= 1'b0;
      busy_q        <= 1'b0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_first_q <= 1'b0;
      ack_valid_q   <= 1'b0;
      ack_bit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      first_q       <= first_d;
      busy_q        <= busy_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      frame_first_q <= frame_first_d;
      ack_valid_q   <= ack_valid_d;
      ack_bit_q     <= ack_bit_d;
    end
  end

  assign bus.scl_f       = scl_f;
  assign bus.sda_f       = sda_f;
  assign bus.scl_rise    = scl_rise;
  assign bus.scl_fall    = scl_fall;
  assign bus.start_det   = start_ev;
  assign bus.stop_det    = stop_ev;
  assign bus.bus_busy    = busy_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.byte_data   = byte_data_q;
  assign bus.frame_first = frame_first_q;
  assign bus.ack_valid   = ack_valid_q;
  assign bus.ack_bit     = ack_bit_q;
  assign bus.timeout     = tmo;

endmodule

// File: doc/i2c_bus_frontend.md
Name: i2c_bus_frontend

Overview:
- Upstream conditioning stage for the I2C slave controller: synchronises and glitch-filters raw SCL/SDA, detects START/STOP, and assembles serial bits into bytes plus the ACK slot.
- Runs on the fabric clock `clk`; the downstream controller consumes its single-cycle event pulses instead of sampling bus lines directly.

Parameters:
- FILTER_LEN, 3: consecutive cycles a synchronised line must disagree with its filtered value before the filtered value flips (1..15).
- TIMEOUT_CYCLES, 1024: SCL-low cycles while busy before a timeout fires (used only with the optional feature).

Ports:
- clk  in  1  fabric clock
- rst  in  1  asynchronous reset, active-high
- scl_in  in  1  raw SCL
- sda_in  in  1  raw SDA
- scl_f  out  1  filtered SCL
- sda_f  out  1  filtered SDA
- scl_rise  out  1  one-cycle pulse, filtered SCL 0->1
- scl_fall  out  1  one-cycle pulse, filtered SCL 1->0
- start_det  out  1  one-cycle pulse, START or repeated START
- stop_det  out  1  one-cycle pulse, STOP
- bus_busy  out  1  high between START and STOP
- byte_valid  out  1  one-cycle pulse, byte_data valid
- byte_data  out  8  last assembled byte, MSB first on the wire
- frame_first  out  1  qualifies byte_valid: first byte after a START (address byte)
- ack_valid  out  1  one-cycle pulse on the 9th SCL rise
- ack_bit  out  1  SDA sampled in the ACK slot (0 = ACK)
- timeout  out  1  one-cycle pulse, bus timeout; tied 0 without I2C_TIMEOUT_EN

Behaviour:
- Reset (async, rst=1):
  - sync flops, scl_f and sda_f = 1; filter counters = 0.
  - State = IDLE; byte_data = 0x00; all pulses, bus_busy and ack_bit = 0.
- Synchroniser: 2-flop per line, reset to 1.
- Filter:
  - Counter increments while the synchronised value != filtered value; it clears whenever they agree.
  - When the counter reaches FILTER_LEN-1 with the mismatch still present, the filtered value flips and the counter clears.
  - Raw-to-filtered latency = 2+FILTER_LEN cycles; pulses shorter than FILTER_LEN cycles are suppressed.
- Edges: scl_prev/sda_prev hold the filtered values delayed by one cycle; every event pulse is high exactly on the first cycle the new filtered value is visible.
- START = sda_f falls while scl_f=1 and scl_prev=1. STOP = sda_f rises under the same condition.
- SCL and SDA changing in the same cycle: scl edge only, no START/STOP.
- bus_busy: set on START, cleared on STOP or timeout.
- FSM states IDLE, DATA, ACK:
  - IDLE: SCL edges ignored. START -> DATA, bit_cnt=0, first_flag=1.
  - DATA: each scl_rise shifts sda_f into the shift register LSB and increments bit_cnt. On the 8th rise, the next cycle: byte_data loads, byte_valid=1, frame_first=first_flag, first_flag clears, state -> ACK.
  - ACK: the 9th scl_rise drives ack_valid=1 and ack_bit=sda_f in the next cycle; state -> DATA, bit_cnt=0.
  - START in DATA/ACK (repeated START): partial byte discarded, no byte_valid, -> DATA, bit_cnt=0, first_flag=1.
  - STOP in any state: -> IDLE, partial byte discarded.
  - START/STOP take priority over a coincident bit event.
- byte_data holds its value until the next byte_valid.

Optional Feature:
- Macro I2C_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES)+1 increments while bus_busy=1 and scl_f=0; it clears otherwise.
  - Reaching TIMEOUT_CYCLES-1 drives timeout=1 for one cycle, clears bus_busy and sets FSM -> IDLE.
- Undefined: no counter; timeout tied 0.

Decomposition:
- Package i2c_pkg: FSM state typedef (IDLE, DATA, ACK), BYTE_W=8, BITS_PER_BYTE=8, IDLE_LINE=1'b1.
- Sub-module i2c_glitch_filter (2-flop sync + FILTER_LEN counter), instantiated once for SCL and once for SDA.

Test Plan:
- Reset asserted mid-byte -> all outputs at reset values immediately (async), scl_f=sda_f=1, state IDLE; no pulses after deassert until a new START.
- START, bits 0x54 (addr 0x2A + W), ACK slot SDA=0, STOP -> start_det, byte_valid with byte_data=0x54 and frame_first=1, ack_valid with ack_bit=0, stop_det, bus_busy back to 0.
- FILTER_LEN=3: 2-cycle low glitch on SCL during DATA -> no scl_fall, bit_cnt unchanged. A 3-cycle low pulse -> scl_fall, and scl_rise on release.
- START, 5 bits, repeated START, then 0xA5 -> exactly one byte_valid (0xA5, frame_first=1); the partial byte never appears.
- SCL and SDA toggled in the same raw cycle while SCL high -> no start_det/stop_det.
- I2C_TIMEOUT_EN, TIMEOUT_CYCLES=1024: START, then SCL held low 1024 cycles -> one timeout pulse, bus_busy=0, state IDLE. Without the macro -> timeout stays 0, bus_busy stays 1.
